// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM stage: byte-lane masks, FSM states, timeout default.
package mem_access_pkg;

  // Byte-lane masks accepted on mem_sel
  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b0011;
  localparam logic [3:0] SEL_H1 = 4'b1100;
  localparam logic [3:0] SEL_W  = 4'b1111;

  // Bus access FSM
  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  // Wide enough for the largest supported timeout (1023)
  localparam int CNT_W = 10;

  // Only naturally aligned byte, half and word masks are accepted
  function automatic logic sel_is_legal(input logic [3:0] sel);
    case (sel)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3, SEL_H0, SEL_H1, SEL_W: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data alignment: picks the selected byte/half of the bus word, moves it
// to bit 0 and sign- or zero-extends it to the full data width.
module mem_load_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] ram_read_data,
  input  logic [3:0]        sel,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] data
);

  // Lane select plus extension; unknown masks pass the word through unchanged
  always_comb begin
    data = ram_read_data;
    case (sel)
      SEL_B0: data = {{(DATA_W-8){sign_ext & ram_read_data[7]}},   ram_read_data[7:0]};
      SEL_B1: data = {{(DATA_W-8){sign_ext & ram_read_data[15]}},  ram_read_data[15:8]};
      SEL_B2: data = {{(DATA_W-8){sign_ext & ram_read_data[23]}},  ram_read_data[23:16]};
      SEL_B3: data = {{(DATA_W-8){sign_ext & ram_read_data[31]}},  ram_read_data[31:24]};
      SEL_H0: data = {{(DATA_W-16){sign_ext & ram_read_data[15]}}, ram_read_data[15:0]};
      SEL_H1: data = {{(DATA_W-16){sign_ext & ram_read_data[31]}}, ram_read_data[31:16]};
      default: data = ram_read_data;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores on a ready-handshaked RAM bus,
// aligns load data and registers the writeback bundle for WB. Upstream is
// stalled while an access is outstanding; hung accesses are abandoned after
// TIMEOUT request cycles.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic              mem_sign_ext_flag,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] result_in,
  input  logic              reg_write_en_in,
  input  logic [4:0]        reg_write_addr_in,
  input  logic [ADDR_W-1:0] current_pc_addr_in,
  output logic              stall_req,
  output logic              ram_en,
  output logic [3:0]        ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] result_out,
  output logic              reg_write_en_out,
  output logic [4:0]        reg_write_addr_out,
  output logic [ADDR_W-1:0] current_pc_addr_out,
  output logic              access_error
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [3:0]         sel_reg;
  logic               sign_ext_reg;
  logic               is_load_reg;
  logic [DATA_W-1:0]  alu_result_reg;
  logic               wb_en_reg;
  logic [4:0]         wb_addr_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic               kill_reg;

  logic               is_mem;
  logic               is_store;
  logic               kill_now;
  logic [DATA_W-1:0]  store_lane_data;
  logic [DATA_W-1:0]  load_data;

  assign is_mem    = mem_read_flag | mem_write_flag;
  // A store flag wins if both flags are set, so the bus never sees a load with strobes
  assign is_store  = mem_write_flag;
  // A flush on the completing cycle kills the writeback just like an earlier one
  assign kill_now  = kill_reg | flush;
  assign stall_req = (state_reg == S_REQ);

  mem_load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .ram_read_data(ram_read_data),
    .sel          (sel_reg),
    .sign_ext     (sign_ext_reg),
    .data         (load_data)
  );

  // Store lane placement: replicate bytes/halves so every lane the strobes select carries the data
  always_comb begin
    store_lane_data = mem_write_data;
    case (mem_sel)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3: store_lane_data = {4{mem_write_data[7:0]}};
      SEL_H0, SEL_H1:                 store_lane_data = {2{mem_write_data[15:0]}};
      default:                        store_lane_data = mem_write_data;
    endcase
  end

  // Access FSM with registered bus and writeback outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg           <= S_IDLE;
      cnt_reg             <= '0;
      sel_reg             <= '0;
      sign_ext_reg        <= 1'b0;
      is_load_reg         <= 1'b0;
      alu_result_reg      <= '0;
      wb_en_reg           <= 1'b0;
      wb_addr_reg         <= '0;
      pc_reg              <= '0;
      kill_reg            <= 1'b0;
      ram_en              <= 1'b0;
      ram_write_en        <= '0;
      ram_addr            <= '0;
      ram_write_data      <= '0;
      out_valid           <= 1'b0;
      result_out          <= '0;
      reg_write_en_out    <= 1'b0;
      reg_write_addr_out  <= '0;
      current_pc_addr_out <= '0;
      access_error        <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      access_error <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              // Plain ALU op: one-cycle pass-through unless flushed
              if (!flush) begin
                out_valid           <= 1'b1;
                result_out          <= result_in;
                reg_write_en_out    <= reg_write_en_in;
                reg_write_addr_out  <= reg_write_addr_in;
                current_pc_addr_out <= current_pc_addr_in;
              end
            end else if (!sel_is_legal(mem_sel)) begin
              // Misaligned/unsupported lane mask: no bus request, retire without writeback
              access_error        <= 1'b1;
              out_valid           <= !flush;
              result_out          <= result_in;
              reg_write_en_out    <= 1'b0;
              reg_write_addr_out  <= reg_write_addr_in;
              current_pc_addr_out <= current_pc_addr_in;
            end else if (!flush) begin
              // Legal access: latch everything the bus and writeback need, then request
              state_reg      <= S_REQ;
              cnt_reg        <= '0;
              kill_reg       <= 1'b0;
              sel_reg        <= mem_sel;
              sign_ext_reg   <= mem_sign_ext_flag;
              is_load_reg    <= !is_store;
              alu_result_reg <= result_in;
              wb_en_reg      <= reg_write_en_in;
              wb_addr_reg    <= reg_write_addr_in;
              pc_reg         <= current_pc_addr_in;
              ram_en         <= 1'b1;
              ram_write_en   <= is_store ? mem_sel : 4'b0000;
              ram_addr       <= {result_in[ADDR_W-1:2], 2'b00};
              ram_write_data <= store_lane_data;
            end
          end
        end
        S_REQ: begin
          if (flush) begin
            kill_reg <= 1'b1;
          end
          if (ram_ready) begin
            state_reg           <= S_IDLE;
            ram_en              <= 1'b0;
            ram_write_en        <= 4'b0000;
            out_valid           <= !kill_now;
            result_out          <= is_load_reg ? load_data : alu_result_reg;
            reg_write_en_out    <= is_load_reg & wb_en_reg & !kill_now;
            reg_write_addr_out  <= wb_addr_reg;
            current_pc_addr_out <= pc_reg;
          end else if (cnt_reg == CNT_LAST) begin
            // Bus never answered: abandon the access and retire without writeback
            state_reg           <= S_IDLE;
            ram_en              <= 1'b0;
            ram_write_en        <= 4'b0000;
            access_error        <= 1'b1;
            out_valid           <= !kill_now;
            result_out          <= alu_result_reg;
            reg_write_en_out    <= 1'b0;
            reg_write_addr_out  <= wb_addr_reg;
            current_pc_addr_out <= pc_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ram_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a table of directed vectors, a few
// hand-written flush/reset sequences, and randomized transactions checked
// against a lane-arithmetic reference model.
module tb_mem_access;

  localparam int TMO = 8;
  localparam int NO_FLUSH = -99;
  localparam int ACCEPT_FLUSH = -1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        mem_read_flag = 1'b0;
  logic        mem_write_flag = 1'b0;
  logic        mem_sign_ext_flag = 1'b0;
  logic [3:0]  mem_sel = 4'b0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] result_in = '0;
  logic        reg_write_en_in = 1'b0;
  logic [4:0]  reg_write_addr_in = '0;
  logic [31:0] current_pc_addr_in = '0;
  logic        stall_req;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_read_data = '0;
  logic        out_valid;
  logic [31:0] result_out;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] current_pc_addr_out;
  logic        access_error;

  int n_pass = 0;
  int n_total = 0;

  mem_access #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .flush              (flush),
    .mem_read_flag      (mem_read_flag),
    .mem_write_flag     (mem_write_flag),
    .mem_sign_ext_flag  (mem_sign_ext_flag),
    .mem_sel            (mem_sel),
    .mem_write_data     (mem_write_data),
    .result_in          (result_in),
    .reg_write_en_in    (reg_write_en_in),
    .reg_write_addr_in  (reg_write_addr_in),
    .current_pc_addr_in (current_pc_addr_in),
    .stall_req          (stall_req),
    .ram_en             (ram_en),
    .ram_write_en       (ram_write_en),
    .ram_addr           (ram_addr),
    .ram_write_data     (ram_write_data),
    .ram_ready          (ram_ready),
    .ram_read_data      (ram_read_data),
    .out_valid          (out_valid),
    .result_out         (result_out),
    .reg_write_en_out   (reg_write_en_out),
    .reg_write_addr_out (reg_write_addr_out),
    .current_pc_addr_out(current_pc_addr_out),
    .access_error       (access_error)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] legal_list [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  function automatic bit sel_ok(input logic [3:0] s);
    for (int i = 0; i < 7; i++) if (legal_list[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int low_lane(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return 0;
  endfunction

  function automatic int lane_count(input logic [3:0] s);
    int c = 0;
    for (int i = 0; i < 4; i++) if (s[i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [3:0] s, input logic ext);
    logic [31:0] v;
    logic [31:0] m;
    int nb;
    nb = lane_count(s);
    v = rd >> (8 * low_lane(s));
    if (nb < 4) begin
      m = (32'h1 << (8 * nb)) - 32'h1;
      v = v & m;
      if (ext && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] store_model(input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] v = '0;
    int lo;
    lo = low_lane(s);
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = wd[8*(i-lo) +: 8];
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " stall_req"}, 32'(stall_req), 0);
    check({nm, " ram_en"}, 32'(ram_en), 0);
    check({nm, " ram_write_en"}, 32'(ram_write_en), 0);
    check({nm, " ram_addr"}, ram_addr, 0);
    check({nm, " ram_write_data"}, ram_write_data, 0);
    check({nm, " out_valid"}, 32'(out_valid), 0);
    check({nm, " result_out"}, result_out, 0);
    check({nm, " reg_write_en_out"}, 32'(reg_write_en_out), 0);
    check({nm, " reg_write_addr_out"}, 32'(reg_write_addr_out), 0);
    check({nm, " pc_out"}, current_pc_addr_out, 0);
    check({nm, " access_error"}, 32'(access_error), 0);
  endtask

  // One instruction from IDLE to retirement. Called #1 after a clock edge;
  // returns #1 after the retiring edge so the next call issues back-to-back.
  task automatic do_txn(input string nm, input logic rd, input logic wr, input logic ext,
                        input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] res,
                        input logic wben, input logic [4:0] wba, input logic [31:0] pc,
                        input logic [31:0] rdata, input int wait_n, input int flush_cyc,
                        input logic [31:0] exp_res, input logic exp_wben);
    bit is_mem;
    bit legal;
    bit killed;
    bit timed_out;
    int cycles;
    int stall_cnt;
    is_mem = rd | wr;
    legal = sel_ok(sel);
    killed = 1'b0;
    in_valid = 1'b1;
    mem_read_flag = rd;
    mem_write_flag = wr;
    mem_sign_ext_flag = ext;
    mem_sel = sel;
    mem_write_data = wdata;
    result_in = res;
    reg_write_en_in = wben;
    reg_write_addr_in = wba;
    current_pc_addr_in = pc;
    flush = (flush_cyc == ACCEPT_FLUSH);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check({nm, " acc_err"}, 32'(access_error), 32'(is_mem && !legal));
    if (!is_mem || !legal || flush_cyc == ACCEPT_FLUSH) begin
      check({nm, " ram_en"}, 32'(ram_en), 0);
      check({nm, " stall"}, 32'(stall_req), 0);
      check({nm, " out_valid"}, 32'(out_valid), 32'(flush_cyc != ACCEPT_FLUSH));
      if (flush_cyc != ACCEPT_FLUSH) begin
        check({nm, " result"}, result_out, exp_res);
        check({nm, " wb_en"}, 32'(reg_write_en_out), 32'(exp_wben));
        check({nm, " wb_addr"}, 32'(reg_write_addr_out), 32'(wba));
        check({nm, " pc"}, current_pc_addr_out, pc);
      end
      $display("txn %s: op=%0d sel=%b retired at once", nm, is_mem, sel);
      return;
    end
    check({nm, " ram_en"}, 32'(ram_en), 1);
    check({nm, " out_valid busy"}, 32'(out_valid), 0);
    check({nm, " ram_addr"}, ram_addr, res & 32'hFFFF_FFFC);
    check({nm, " strobes"}, 32'(ram_write_en), wr ? 32'(sel) : 32'h0);
    if (wr) check({nm, " wdata"}, ram_write_data & lane_mask(sel), store_model(wdata, sel));
    stall_cnt = stall_req ? 1 : 0;
    cycles = 0;
    for (int n = 0; n < TMO + 4; n++) begin
      ram_ready = (n == wait_n);
      ram_read_data = (n == wait_n) ? rdata : $urandom;
      flush = (n == flush_cyc);
      if (n == flush_cyc) killed = 1'b1;
      @(posedge clk); #1;
      ram_ready = 1'b0;
      flush = 1'b0;
      cycles = n + 1;
      if (!ram_en) break;
      if (stall_req) stall_cnt++;
    end
    check({nm, " done"}, 32'(ram_en), 0);
    timed_out = (wait_n >= TMO);
    check({nm, " req_cycles"}, 32'(cycles), timed_out ? 32'(TMO) : 32'(wait_n + 1));
    check({nm, " stall_cycles"}, 32'(stall_cnt), 32'(cycles));
    check({nm, " stall_end"}, 32'(stall_req), 0);
    check({nm, " strobes_end"}, 32'(ram_write_en), 0);
    check({nm, " acc_err_end"}, 32'(access_error), 32'(timed_out));
    check({nm, " out_valid"}, 32'(out_valid), 32'(!killed));
    check({nm, " wb_en"}, 32'(reg_write_en_out), killed ? 32'h0 : 32'(exp_wben));
    if (!killed) begin
      check({nm, " result"}, result_out, exp_res);
      check({nm, " wb_addr"}, 32'(reg_write_addr_out), 32'(wba));
      check({nm, " pc"}, current_pc_addr_out, pc);
    end
    $display("txn %s: sel=%b wr=%0d cycles=%0d killed=%0d timeout=%0d", nm, sel, wr, cycles, killed, timed_out);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic        ext;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] res;
    logic [31:0] rdata;
    int          wait_n;
    logic [31:0] exp_res;
    logic        exp_wben;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd, wr, ext, wben;
    logic [3:0] sel;
    logic [31:0] wdata, res, rdata, exp_res;
    logic exp_wben;
    int wait_n, fl, kind;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,    32'h1234, 32'h0,          0,   32'h1234,     1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'b0010, 32'h0,    32'h100,  32'h0000_8000,  3,   32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'b0010, 32'h0,    32'h100,  32'h0000_8000,  0,   32'h0000_0080, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'b1100, 32'hABCD, 32'h202,  32'h0,          0,   32'h202,      1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'b1100, 32'h0,    32'h302,  32'h8001_0000,  1,   32'hFFFF_8001, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'b1111, 32'h0,    32'h400,  32'hDEAD_BEEF,  2,   32'hDEAD_BEEF, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'b1000, 32'h0,    32'h503,  32'h7F00_0000,  0,   32'h0000_007F, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'b0011, 32'h0,    32'h600,  32'h1234_F00D,  7,   32'h0000_F00D, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h0,    32'h700,  32'h0,          100, 32'h700,      1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 32'h55,   32'h800,  32'h0,          0,   32'h800,      1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'b0100, 32'h5A,   32'h41,   32'h0,          1,   32'h41,       1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 4'b0001, 32'h0,    32'h44,   32'h0000_00FF,  0,   32'hFFFF_FFFF, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].ext, vecs[i].sel,
             vecs[i].wdata, vecs[i].res, 1'b1, 5'(i + 1), 32'h1000 + 32'(4 * i),
             vecs[i].rdata, vecs[i].wait_n, NO_FLUSH, vecs[i].exp_res, vecs[i].exp_wben);
    end

    // Flush while a load is outstanding; next instruction issues right after completion
    do_txn("flush_req", 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h900, 1'b1, 5'd9, 32'h2000,
           32'h1111_1111, 2, 0, 32'h1111_1111, 1'b1);
    do_txn("after_flush", 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'hCAFE, 1'b1, 5'd10, 32'h2004,
           32'h0, 0, NO_FLUSH, 32'hCAFE, 1'b1);
    // Flush on an instruction accepted in IDLE
    do_txn("flush_idle", 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'hBEEF, 1'b1, 5'd11, 32'h2008,
           32'h0, 0, ACCEPT_FLUSH, 32'hBEEF, 1'b1);

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      rd = (kind == 1);
      wr = (kind == 2);
      ext = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_list[$urandom_range(0, 6)];
      wdata = $urandom;
      res = $urandom;
      rdata = $urandom;
      wben = 1'($urandom_range(0, 1));
      wait_n = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 4);
      fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, wait_n) : NO_FLUSH;
      if (!(rd || wr)) begin
        exp_res = res;
        exp_wben = wben;
      end else if (!sel_ok(sel)) begin
        exp_res = res;
        exp_wben = 1'b0;
      end else if (wait_n >= TMO) begin
        exp_res = res;
        exp_wben = 1'b0;
      end else if (rd) begin
        exp_res = load_model(rdata, sel, ext);
        exp_wben = wben;
      end else begin
        exp_res = res;
        exp_wben = 1'b0;
      end
      do_txn($sformatf("rnd%0d", t), rd, wr, ext, sel, wdata, res, wben, 5'($urandom),
             $urandom, rdata, wait_n, fl, exp_res, exp_wben);
    end

    // Reset asserted mid-access aborts it asynchronously
    in_valid = 1'b1;
    mem_read_flag = 1'b1;
    mem_write_flag = 1'b0;
    mem_sel = 4'b1111;
    result_in = 32'hA00;
    reg_write_en_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("midreset ram_en before", 32'(ram_en), 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    $display("txn midreset: reset asserted during REQ");
    @(posedge clk); #1;
    rst = 1'b1;
    do_txn("post_reset", 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h77, 1'b1, 5'd3, 32'h3000,
           32'h0, 0, NO_FLUSH, 32'h77, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage; sits directly downstream of EX and consumes its outputs: memory flags, sel, store data, ALU result as address, writeback info.
- Performs load/store on a ready-handshaked data RAM bus.
- Aligns and extends load data, then registers the writeback bundle to WB.
- Stalls upstream while a memory access is outstanding; times out hung accesses.

Parameters:
- ADDR_W, 32, address width (matches ADDR_BUS)
- DATA_W, 32, data width (matches DATA_BUS)
- TIMEOUT, 255, max REQ cycles before access is abandoned (1..1023)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  EX output bundle valid this cycle
- flush  in  1  squash current/in-flight instruction writeback
- mem_read_flag  in  1  load
- mem_write_flag  in  1  store
- mem_sign_ext_flag  in  1  sign-extend load data
- mem_sel  in  4  byte-lane mask
- mem_write_data  in  DATA_W  store data, right-justified
- result_in  in  DATA_W  ALU result / effective address
- reg_write_en_in  in  1  writeback enable
- reg_write_addr_in  in  5  destination register
- current_pc_addr_in  in  ADDR_W  PC of instruction
- stall_req  out  1  hold upstream; high whenever state != IDLE
- ram_en  out  1  bus request
- ram_write_en  out  4  per-lane write strobes (0 for loads)
- ram_addr  out  ADDR_W  word-aligned address {result_in[31:2],2'b00}
- ram_write_data  out  DATA_W  lane-shifted store data
- ram_ready  in  1  bus completion, valid only while ram_en
- ram_read_data  in  DATA_W  read word, valid with ram_ready
- out_valid  out  1  WB bundle valid
- result_out  out  DATA_W  ALU result or aligned load data
- reg_write_en_out  out  1  qualified writeback enable
- reg_write_addr_out  out  5  destination
- current_pc_addr_out  out  ADDR_W  PC
- access_error  out  1  one-cycle pulse: bad sel or timeout

Behaviour:
- Reset (rst low, async): state=IDLE, counter=0; all registered outputs 0, including ram_en, ram_write_en, out_valid, access_error.
- FSM states: IDLE, REQ.
- IDLE, in_valid, non-memory op: next edge registers the bundle to the outputs with out_valid=1. Latency 1.
- IDLE, in_valid, memory op, legal sel: latch address, sel, data, ext, wb info. Go to REQ. out_valid=0 next cycle.
- Legal sel values:
  - load: 0001, 0010, 0100, 1000, 0011, 1100, 1111
  - store: the same set
  - any other sel: no bus request, out_valid=1 with reg_write_en_out=0, access_error pulse, stay IDLE.
- REQ: ram_en=1. Address, strobes and data are held stable from latched registers.
  - Store lanes: byte data replicated to the selected lane; half data to the selected half; word unchanged.
- REQ, ram_ready sampled 1: next edge goes to IDLE, ram_en=0, out_valid=1.
  - Load: result_out = selected byte/half shifted to bit 0, then sign-extended (mem_sign_ext_flag) or zero-extended.
  - Store: result_out = latched ALU result, reg_write_en_out=0.
  - Zero-wait ready gives load-to-output latency 2.
- REQ counter increments each cycle without ready. At count == TIMEOUT-1 with no ready: drop ram_en, go to IDLE, out_valid=1, reg_write_en_out=0, access_error pulse.
- flush:
  - In IDLE: the accepted instruction yields out_valid=0.
  - In REQ: the bus access completes or times out normally, but out_valid stays 0 and reg_write_en_out=0. A sticky kill bit records the flush.
- in_valid is ignored while state == REQ; upstream must hold its inputs under stall_req.
- Outputs hold their values except out_valid, which drops to 0 on any cycle with no completion.
- Reset asserted mid-REQ aborts the access immediately: ram_en=0, nothing is written back.

Decomposition:
- Shared package/header holds:
  - mem_sel lane encodings (SEL_B0..B3, SEL_H0, SEL_H1, SEL_W)
  - FSM state encodings
  - TIMEOUT default
- Sub-module mem_load_align: combinational lane select plus sign/zero extension.
  - Ports: ram_read_data, sel, sign_ext → data out.
  - Store lane-shift logic stays inline in mem_access.

Test Plan:
- Non-mem op: result_in=0x1234, reg_write_en_in=1, addr 5 → next cycle out_valid=1, result_out=0x1234, reg_write_en_out=1, stall_req never high.
- Signed byte load: result_in=0x100, sel=0010, sign_ext=1, ram_read_data=0x0000_8000, ready after 3 cycles → ram_addr=0x100, stall_req high 4 cycles, result_out=0xFFFF_FF80.
- Half store: sel=1100, write_data=0xABCD, addr 0x202 → ram_write_en=1100, ram_write_data[31:16]=0xABCD, reg_write_en_out=0.
- Timeout: TIMEOUT=8, ram_ready held 0 → ram_en high exactly 8 cycles, access_error one pulse, out_valid=1, reg_write_en_out=0, back to IDLE.
- Flush during REQ on a load, ready 2 cycles later → out_valid stays 0; next instruction accepted the cycle after completion.
- Illegal sel=0101 → no ram_en, access_error pulse, reg_write_en_out=0. Separately, rst low mid-REQ → all outputs 0 asynchronously.
